// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler and the stage registers
// that consume its hold/bubble controls.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam int MEM_TIMEOUT_DEF = 16;

    // One bundle for every hold/bubble control, so the stage registers can take it as one port.
    typedef struct packed {
        logic stop_pc;
        logic stop_if_id;
        logic stop_id_ex;
        logic stop_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_mem_wb;
    } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; used for the performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + WIDTH'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler: arbitrates data-memory waits, EX redirects and load-use
// hazards into pipeline-register hold/bubble controls, with perf counters and a timeout flag.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             load_use_req,
    input  logic             redirect_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ack,
    output logic             stop_PC,
    output logic             stop_IF_ID,
    output logic             stop_ID_EX,
    output logic             stop_EX_MEM,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_MEM_WB,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    ctrl_t             ctrl;

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    // wait_cnt sits at zero in RUN, so it is already clear on entry to MEM_WAIT.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            if (state == RUN)
                wait_cnt <= '0;
            else if (state == MEM_WAIT)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (state_nxt == ERR)
                mem_err <= 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        ctrl      = '0;

        unique case (state)
            RUN: begin
                if (dmem_req_MEM && !dmem_ack) begin
                    state_nxt = MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_nxt = RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
                        state_nxt = ERR;
                end
            end
            ERR:     mem_stall = 1'b1;
            default: state_nxt = RUN;
        endcase

        // Outputs are forced quiet while reset is held, even with requests pending.
        if (cpu_rst) begin
            ctrl = '0;
        end else if (mem_stall) begin
            ctrl.stop_pc      = 1'b1;
            ctrl.stop_if_id   = 1'b1;
            ctrl.stop_id_ex   = 1'b1;
            ctrl.stop_ex_mem  = 1'b1;
            ctrl.flush_mem_wb = 1'b1;
        end else if (redirect_EX) begin
            ctrl.flush_if_id = 1'b1;
            ctrl.flush_id_ex = 1'b1;
        end else if (load_use_req) begin
            ctrl.stop_pc     = 1'b1;
            ctrl.stop_if_id  = 1'b1;
            ctrl.flush_id_ex = 1'b1;
        end
    end

    assign stop_PC      = ctrl.stop_pc;
    assign stop_IF_ID   = ctrl.stop_if_id;
    assign stop_ID_EX   = ctrl.stop_id_ex;
    assign stop_EX_MEM  = ctrl.stop_ex_mem;
    assign flush_IF_ID  = ctrl.flush_if_id;
    assign flush_ID_EX  = ctrl.flush_id_ex;
    assign flush_MEM_WB = ctrl.flush_mem_wb;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .inc     (ctrl.stop_pc),
        .count   (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .inc     (ctrl.flush_if_id),
        .count   (flush_cnt)
    );

endmodule
